// File: rtl/cmp_result_monitor.sv
// Checker and statistics stage behind the 4-bit magnitude comparator.
// Verifies flags, counts results, tracks A range and equal-run lock.
module cmp_result_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid_in,
  input  logic [3:0]       a_in,
  input  logic [3:0]       b_in,
  input  logic             a_gret,
  input  logic             a_lt,
  input  logic             a_eq,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       max_a,
  output logic [3:0]       min_a,
  output logic             lock,
  output logic             err_sticky,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       RUN_MAX = 4'(LOCK_LEN);
  localparam logic [CNT_W-1:0] ONE     = 1;

  state_t     st, st_nxt;
  logic [3:0] eq_run, run_nxt;
  logic       ref_gt, ref_lt, ref_eq;
  logic       good, good_eq;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + ONE;
  endfunction

  always_comb begin
    ref_gt  = a_in > b_in;
    ref_lt  = a_in < b_in;
    ref_eq  = a_in == b_in;
    // reference is one-hot, so equality means exactly one matching flag
    good    = {a_gret, a_lt, a_eq} == {ref_gt, ref_lt, ref_eq};
    good_eq = good && ref_eq;
    run_nxt = 4'd0;
    if (good_eq)
      run_nxt = (eq_run >= RUN_MAX) ? RUN_MAX : eq_run + 4'd1;
    st_nxt = TRACK;
    unique case (st)
      IDLE, TRACK:
        st_nxt = (run_nxt == RUN_MAX) ? LOCKED : TRACK;
      LOCKED:
        st_nxt = good_eq ? LOCKED : TRACK;
      default:
        st_nxt = TRACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      gt_count   <= '0;
      lt_count   <= '0;
      eq_count   <= '0;
      err_count  <= '0;
      max_a      <= 4'd0;
      min_a      <= 4'd15;
      lock       <= 1'b0;
      err_sticky <= 1'b0;
      eq_run     <= 4'd0;
      st         <= IDLE;
    end else if (valid_in) begin
      if (good) begin
        unique case (1'b1)
          ref_gt:  gt_count <= sat_inc(gt_count);
          ref_lt:  lt_count <= sat_inc(lt_count);
          default: eq_count <= sat_inc(eq_count);
        endcase
        if (a_in > max_a) max_a <= a_in;
        if (a_in < min_a) min_a <= a_in;
      end else begin
        err_count  <= sat_inc(err_count);
        err_sticky <= 1'b1;
      end
      eq_run <= run_nxt;
      st     <= st_nxt;
      lock   <= st_nxt == LOCKED;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Three monitor configurations on shared stimulus, checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_cmp_result_monitor;

  logic       clk = 1'b0;
  logic       rst, clear, valid_in;
  logic [3:0] a_in, b_in;
  logic       a_gret, a_lt, a_eq;

  logic [7:0] gt_c[3], lt_c[3], eq_c[3], er_c[3];
  logic [3:0] mx_c[3], mn_c[3];
  logic       lk_c[3], es_c[3];
  logic [1:0] st_c[3];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int CW = (k == 0) ? 8 : 4;
    localparam int LL = (k == 2) ? 1 : 4;
    logic [CW-1:0] gt, lt, eq, er;
    cmp_result_monitor #(.CNT_W(CW), .LOCK_LEN(LL)) dut (
      .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in),
      .a_in(a_in), .b_in(b_in),
      .a_gret(a_gret), .a_lt(a_lt), .a_eq(a_eq),
      .gt_count(gt), .lt_count(lt), .eq_count(eq), .err_count(er),
      .max_a(mx_c[k]), .min_a(mn_c[k]), .lock(lk_c[k]),
      .err_sticky(es_c[k]), .state(st_c[k])
    );
    assign gt_c[k] = 8'(gt);
    assign lt_c[k] = 8'(lt);
    assign eq_c[k] = 8'(eq);
    assign er_c[k] = 8'(er);
  end

  int cmax[3] = '{255, 15, 15};
  int llen[3] = '{4, 4, 1};

  // model: cnt[k][0]=gt, [1]=lt, [2]=eq, [3]=err
  int cnt[3][4];
  int m_mx[3], m_mn[3], m_run[3];
  bit m_es[3], m_seen[3];

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int exp_state(input int k);
    if (!m_seen[k]) return 0;
    return (m_run[k] == llen[k]) ? 2 : 1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst || clear) begin
        for (int j = 0; j < 4; j++) cnt[k][j] = 0;
        m_mx[k] = 0; m_mn[k] = 15; m_run[k] = 0;
        m_es[k] = 0; m_seen[k] = 0;
      end else if (valid_in) begin
        int r, nf;
        bit ok;
        r  = (a_in > b_in) ? 0 : (a_in < b_in) ? 1 : 2;
        nf = int'(a_gret) + int'(a_lt) + int'(a_eq);
        ok = (nf == 1) && ((r == 0 && a_gret) ||
             (r == 1 && a_lt) || (r == 2 && a_eq));
        m_seen[k] = 1;
        if (ok) begin
          if (cnt[k][r] < cmax[k]) cnt[k][r]++;
          if (int'(a_in) > m_mx[k]) m_mx[k] = int'(a_in);
          if (int'(a_in) < m_mn[k]) m_mn[k] = int'(a_in);
          if (r == 2) begin
            if (m_run[k] < llen[k]) m_run[k]++;
          end else m_run[k] = 0;
        end else begin
          if (cnt[k][3] < cmax[k]) cnt[k][3]++;
          m_es[k] = 1;
          m_run[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        int s;
        s = exp_state(k);
        chk($sformatf("gt%0d", k), gt_c[k], cnt[k][0]);
        chk($sformatf("lt%0d", k), lt_c[k], cnt[k][1]);
        chk($sformatf("eq%0d", k), eq_c[k], cnt[k][2]);
        chk($sformatf("err%0d", k), er_c[k], cnt[k][3]);
        chk($sformatf("max%0d", k), mx_c[k], m_mx[k]);
        chk($sformatf("min%0d", k), mn_c[k], m_mn[k]);
        chk($sformatf("sticky%0d", k), es_c[k], m_es[k]);
        chk($sformatf("state%0d", k), st_c[k], s);
        chk($sformatf("lock%0d", k), lk_c[k], (s == 2) ? 1 : 0);
      end
    end
  end

  task automatic send(input int a, input int b,
                      input bit g, input bit l, input bit e);
    valid_in = 1'b1;
    a_in = 4'(a); b_in = 4'(b);
    a_gret = g; a_lt = l; a_eq = e;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; valid_in = 1'b0;
    a_in = '0; b_in = '0; a_gret = 0; a_lt = 0; a_eq = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1;
    chk("rst_min", mn_c[0], 15);
    chk("rst_state", st_c[0], 0);

    repeat (3) send(9, 3, 1, 0, 0);
    chk("gt3", gt_c[0], 3);
    chk("gt_max", mx_c[0], 9);
    chk("gt_min", mn_c[0], 9);
    chk("gt_state", st_c[0], 1);
    chk("gt_err", er_c[0], 0);

    send(5, 5, 0, 0, 1);
    send(5, 5, 0, 0, 1);
    idle();
    send(5, 5, 0, 0, 1);
    chk("eq3_nolock", lk_c[0], 0);
    chk("ll1_locked", st_c[2], 2);
    send(5, 5, 0, 0, 1);
    chk("eq4_lock", lk_c[0], 1);
    chk("eq4_state", st_c[0], 2);
    send(2, 7, 0, 1, 0);
    chk("lt_unlock", lk_c[0], 0);
    chk("lt_state", st_c[0], 1);
    chk("lt1", lt_c[0], 1);
    chk("lt_min", mn_c[0], 2);

    send(4, 4, 1, 0, 0);
    send(1, 8, 0, 0, 0);
    send(6, 2, 1, 0, 1);
    chk("bad_err", er_c[0], 3);
    chk("bad_sticky", es_c[0], 1);
    chk("bad_gt", gt_c[0], 3);
    chk("bad_eq", eq_c[0], 4);
    chk("bad_max", mx_c[0], 9);
    chk("bad_min", mn_c[0], 2);

    repeat (20) send(5, 5, 0, 0, 1);
    idle();
    chk("sat_eq", eq_c[1], 15);
    chk("sat_lock", lk_c[1], 1);
    chk("nosat_eq", eq_c[0], 24);

    clear = 1'b1;
    send(9, 3, 1, 0, 0);
    clear = 1'b0;
    chk("clr_gt", gt_c[0], 0);
    chk("clr_state", st_c[0], 0);
    chk("clr_min", mn_c[0], 15);
    chk("clr_max", mx_c[0], 0);
    chk("clr_sticky", es_c[0], 0);

    repeat (4) send(3, 3, 0, 0, 1);
    chk("relock", lk_c[0], 1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rst_lock", lk_c[0], 0);
    chk("rst_idle", st_c[0], 0);
    chk("rst_min15", mn_c[0], 15);

    send(7, 7, 0, 0, 1);
    chk("ll1_one", st_c[2], 2);
    chk("ll4_one", st_c[0], 1);

    for (int i = 0; i < 3000; i++) begin
      int a, b, m;
      bit g, l, e;
      a = $urandom_range(0, 15);
      b = ($urandom_range(0, 1) == 1) ? a : $urandom_range(0, 15);
      m = $urandom_range(0, 9);
      if (m < 8) begin
        g = a > b; l = a < b; e = a == b;
      end else begin
        {g, l, e} = 3'($urandom_range(0, 7));
      end
      rst   = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) idle();
      else send(a, b, g, l, e);
      rst = 1'b0; clear = 1'b0;
    end

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_result_monitor.md
# cmp_result_monitor

Registered checker and statistics stage placed directly downstream of the 4-bit magnitude comparator. Each cycle it can accept one operand pair and the three comparator flags for that pair. It verifies the flags against its own arithmetic compare of the operands and keeps saturating counts of greater, less-than, equal and bad results. It also tracks the running minimum and maximum of operand A, and raises a lock indication once the operands have been equal for a programmable number of consecutive samples.

## Interface
Parameters:
- CNT_W, default 8: width of every event counter.
- LOCK_LEN, default 4: number of consecutive valid equal samples required for lock. Legal range is 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous clear of all statistics and the FSM. Same effect as rst.
- valid_in  in  1  a sample is presented this cycle.
- a_in  in  4  operand A of the sample. Unsigned.
- b_in  in  4  operand B of the sample. Unsigned.
- a_gret  in  1  comparator flag: A > B.
- a_lt  in  1  comparator flag: A < B.
- a_eq  in  1  comparator flag: A == B.
- gt_count  out  CNT_W  number of good samples with A > B.
- lt_count  out  CNT_W  number of good samples with A < B.
- eq_count  out  CNT_W  number of good samples with A == B.
- err_count  out  CNT_W  number of bad samples.
- max_a  out  4  largest a_in seen among good samples.
- min_a  out  4  smallest a_in seen among good samples.
- lock  out  1  high while the FSM is in LOCKED.
- err_sticky  out  1  set by any bad sample; cleared only by rst or clear.
- state  out  2  FSM state: IDLE=0, TRACK=1, LOCKED=2.

## Operation
- Reset is one clock, synchronous and active-high. After rst or clear:
  - all counters = 0, max_a = 0, min_a = 15;
  - lock = 0, err_sticky = 0, state = IDLE;
  - the internal equal-run counter eq_run = 0.
- Priority: rst, then clear, then the sample. A sample presented in a clear cycle is dropped.
- When valid_in = 0, nothing changes. eq_run is held, so idle gaps do not break an equal run.
- Sample classification, applied only when valid_in = 1:
  - Reference result: GT if a_in > b_in, LT if a_in < b_in, EQ otherwise.
  - Good sample: exactly one flag is high and it matches the reference result.
  - Bad sample: anything else, including zero flags, more than one flag, or a wrong flag.
- Good sample:
  - increment the matching counter;
  - max_a = max(max_a, a_in) and min_a = min(min_a, a_in).
  - If EQ, eq_run = min(eq_run + 1, LOCK_LEN). Otherwise eq_run = 0.
- Bad sample:
  - increment err_count and set err_sticky;
  - eq_run = 0;
  - the gt, lt and eq counters and min_a/max_a are unchanged.
- All counters saturate at 2^CNT_W − 1 and never wrap.
- FSM transitions:
  - IDLE → TRACK on any valid sample. If that sample also brings the next eq_run to LOCK_LEN, go straight to LOCKED; this happens when LOCK_LEN = 1.
  - TRACK → LOCKED when the next eq_run equals LOCK_LEN.
  - LOCKED → TRACK on any valid sample that is not a good EQ sample.
  - LOCKED stays LOCKED on further good EQ samples and on idle cycles.
  - The FSM never returns to IDLE except through rst or clear.

## Timing
- Every output is a register. A sample accepted at edge N is reflected in all outputs after edge N; outputs are stable for the following cycle.
- Latency is 1 cycle, throughput is 1 sample per cycle, and there is no backpressure.
- lock rises in the cycle after the LOCK_LEN-th consecutive good EQ sample. It falls in the cycle after the breaking sample.
- rst or clear asserted mid-run takes effect at that edge, and the outputs show reset values in the next cycle.
- Inputs are sampled only at the rising edge. Combinational glitches on the comparator flags have no effect.

## Test plan
- Reset, then 3 good GT samples (A=9, B=3, a_gret=1) → gt_count = 3, max_a = 9, min_a = 9, state = TRACK, err_count = 0.
- 4 good EQ samples (A = B = 5) with one idle cycle between the 2nd and 3rd → lock = 1 in the cycle after the 4th sample, state = LOCKED. A following good LT sample (A=2, B=7) → lock = 0, state = TRACK, lt_count = 1, min_a = 2.
- Bad flags, one sample each of:
  - A=4, B=4 with a_gret=1 (wrong flag);
  - A=1, B=8 with all flags 0 (no flag);
  - A=6, B=2 with a_gret = a_eq = 1 (two flags);
  → err_count = 3, err_sticky = 1, other counters and min_a/max_a unchanged.
- With CNT_W = 4, send 20 good EQ samples → eq_count = 15 and holds there; lock stays 1.
- clear and a valid GT sample in the same cycle → all outputs at reset values in the next cycle and gt_count = 0. After that, rst during LOCKED → lock = 0, state = IDLE, min_a = 15.
- With LOCK_LEN = 1, a single good EQ sample from IDLE → state = LOCKED in the next cycle.
